// File: rtl/fir_pkg.sv
// fir_pkg: shared types, widths and address arithmetic for fir_sample_buffer.
//   state_t      - sequencer state (IDLE, SEQ)
//   COUNTER_BITS - tap index / address width for the default depth
//   CH_BITS      - channel select width for the default channel count
//   counter_bits, ch_bits - the same widths for any depth / channel count
//   wrap_sub     - circular address of the sample k steps older than head
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  localparam int DEF_TAPS     = 64;
  localparam int DEF_CHANNELS = 2;
  localparam int COUNTER_BITS = $clog2(DEF_TAPS);
  localparam int CH_BITS      = (DEF_CHANNELS > 1) ? $clog2(DEF_CHANNELS) : 1;

  function automatic int counter_bits(input int n);
    return $clog2(n);
  endfunction

  function automatic int ch_bits(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  // Exact for any depth n: never relies on power-of-two wrap-around.
  function automatic int wrap_sub(input int head, input int k, input int n);
    return (head >= k) ? (head - k) : (head + n - k);
  endfunction

endpackage

// File: rtl/fir_sample_buffer_circular_sample_ram.sv
// circular_sample_ram: one channel's delay-line history.
//   clk, rst         - clock, asynchronous active-high reset (clears contents)
//   i_clear          - synchronous clear of all entries (wins over a write)
//   i_we/i_waddr/i_wdata - single write port
//   i_raddr_a/o_rdata_a  - asynchronous read port A
//   i_raddr_b/o_rdata_b  - asynchronous read port B
module circular_sample_ram #(
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clear,
  input  logic                        i_we,
  input  logic [ADDR_BITS-1:0]        i_waddr,
  input  logic signed [DATA_BITS-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0]        i_raddr_a,
  output logic signed [DATA_BITS-1:0] o_rdata_a,
  input  logic [ADDR_BITS-1:0]        i_raddr_b,
  output logic signed [DATA_BITS-1:0] o_rdata_b
);

  logic signed [DATA_BITS-1:0] r_mem [DEPTH];

  // NOTE: this store is reset and cleared as a whole, which rules out a RAM
  // macro; a one-cycle history clear needs every entry to be a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Addresses are always below DEPTH: they come from the wrapped head/tap math.
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/fir_sample_buffer.sv
// fir_sample_buffer: multi-channel circular sample store and tap sequencer.
// Each accepted sample is written once into its channel's circular buffer;
// the block then streams that channel's history, newest first, to the MAC.
//   clk, rst (async, active-high), flush (sync clear of all histories)
//   in_valid/in_ready/in_channel/in_data      - sample input handshake
//   tap_valid/tap_ready/tap_channel/tap_index - tap beat handshake
//   tap_last, tap_data = x[n-k]
//   tap_data_mirror = x[n-(N-1-k)] (only with FIR_SAMPLE_BUFFER_SYMMETRIC_EN)
// Build option FIR_SAMPLE_BUFFER_SYMMETRIC_EN: symmetric-coefficient fold mode,
// N must be even and the sequence covers k = 0..N/2-1.
// in_channel must be below NUM_CHANNELS.
module fir_sample_buffer
  import fir_pkg::*;
#(
  parameter int DATA_BITS      = 16,
  parameter int NUMBER_OF_TAPS = DEF_TAPS,
  parameter int NUM_CHANNELS   = DEF_CHANNELS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [ch_bits(NUM_CHANNELS)-1:0]       in_channel,
  input  logic signed [DATA_BITS-1:0]            in_data,
  output logic                                   tap_valid,
  input  logic                                   tap_ready,
  output logic [ch_bits(NUM_CHANNELS)-1:0]       tap_channel,
  output logic [counter_bits(NUMBER_OF_TAPS)-1:0] tap_index,
  output logic                                   tap_last,
  output logic signed [DATA_BITS-1:0]            tap_data
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
  ,
  output logic signed [DATA_BITS-1:0]            tap_data_mirror
`endif
);

  localparam int KW = counter_bits(NUMBER_OF_TAPS);
  localparam int CW = ch_bits(NUM_CHANNELS);

`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
  if (NUMBER_OF_TAPS % 2 != 0) begin : g_odd_taps
    $error("fir_sample_buffer: symmetric fold mode needs an even NUMBER_OF_TAPS");
  end
  localparam int K_LAST = NUMBER_OF_TAPS / 2 - 1;
`else
  localparam int K_LAST = NUMBER_OF_TAPS - 1;
`endif

  localparam logic [KW-1:0] HEAD_MAX = KW'(NUMBER_OF_TAPS - 1);
  localparam logic [KW-1:0] K_END    = KW'(K_LAST);

  state_t          r_state;
  logic [CW-1:0]   r_ch;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   r_head [NUM_CHANNELS];

  logic [KW-1:0]   w_next_head;
  logic [KW-1:0]   w_addr_a;
  logic            w_accept;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_next_head = (r_head[in_channel] == HEAD_MAX) ? '0 : r_head[in_channel] + 1'b1;
  assign w_addr_a    = KW'(wrap_sub(int'(r_head[r_ch]), int'(r_k), NUMBER_OF_TAPS));

  // NOTE: state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_k     <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_head[c] <= '0;
    end else if (flush) begin
      // Aborts any sequence and drops a same-cycle accept.
      r_state <= IDLE;
      r_ch    <= '0;
      r_k     <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_head[c] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_head[in_channel] <= w_next_head;
            r_ch               <= in_channel;
            r_k                <= '0;
            r_state            <= SEQ;
          end
        end
        SEQ: begin
          if (tap_ready) begin
            if (r_k == K_END) begin
              r_k     <= '0;
              r_state <= IDLE;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic signed [DATA_BITS-1:0] w_rd_a [NUM_CHANNELS];
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
  logic signed [DATA_BITS-1:0] w_rd_b [NUM_CHANNELS];
  logic [KW-1:0]               w_addr_b;
  assign w_addr_b = KW'(wrap_sub(int'(r_head[r_ch]), NUMBER_OF_TAPS - 1 - int'(r_k),
                                 NUMBER_OF_TAPS));
`else
  logic signed [DATA_BITS-1:0] w_unused_rd_b [NUM_CHANNELS];
`endif

  // All channels see the same read address; the active channel's output is muxed.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    circular_sample_ram #(
      .DATA_BITS(DATA_BITS),
      .DEPTH    (NUMBER_OF_TAPS),
      .ADDR_BITS(KW)
    ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (flush),
      .i_we     (w_accept && (in_channel == CW'(g))),
      .i_waddr  (w_next_head),
      .i_wdata  (in_data),
      .i_raddr_a(w_addr_a),
      .o_rdata_a(w_rd_a[g]),
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
      .i_raddr_b(w_addr_b),
      .o_rdata_b(w_rd_b[g])
`else
      .i_raddr_b(w_addr_a),
      .o_rdata_b(w_unused_rd_b[g])
`endif
    );
  end

  assign in_ready    = (r_state == IDLE);
  assign tap_valid   = (r_state == SEQ);
  assign tap_last    = (r_state == SEQ) && (r_k == K_END);
  assign tap_index   = r_k;
  assign tap_channel = r_ch;
  assign tap_data    = w_rd_a[r_ch];
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
  assign tap_data_mirror = w_rd_b[r_ch];
`endif

endmodule

// File: tb/tb_fir_sample_buffer.sv
// tb_fir_sample_buffer: randomized and directed check of fir_sample_buffer
// against a per-channel history queue model (newest sample at the front).
// Instance A: N=64, C=2. Instance B: one channel, N=5 (N=8 in fold mode).
module tb_fir_sample_buffer;

  localparam int NA = 64;
  localparam int CA = 2;
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
  localparam int NB  = 8;
  localparam int KLA = NA / 2 - 1;
  localparam int KLB = NB / 2 - 1;
`else
  localparam int NB  = 5;
  localparam int KLA = NA - 1;
  localparam int KLB = NB - 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic               flush_a = 1'b0, in_valid_a = 1'b0, tap_ready_a = 1'b0;
  logic               in_ready_a, tap_valid_a, tap_last_a;
  logic [0:0]         in_ch_a = '0, tap_ch_a;
  logic signed [15:0] in_data_a = '0, tap_data_a;
  logic [5:0]         tap_index_a;
  // Instance B signals
  logic               flush_b = 1'b0, in_valid_b = 1'b0, tap_ready_b = 1'b0;
  logic               in_ready_b, tap_valid_b, tap_last_b;
  logic [0:0]         in_ch_b = '0, tap_ch_b;
  logic signed [15:0] in_data_b = '0, tap_data_b;
  logic [$clog2(NB)-1:0] tap_index_b;
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
  logic signed [15:0] tap_mirror_a, tap_mirror_b;
`endif

  fir_sample_buffer #(.DATA_BITS(16), .NUMBER_OF_TAPS(NA), .NUM_CHANNELS(CA)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_channel(in_ch_a), .in_data(in_data_a),
    .tap_valid(tap_valid_a), .tap_ready(tap_ready_a), .tap_channel(tap_ch_a),
    .tap_index(tap_index_a), .tap_last(tap_last_a), .tap_data(tap_data_a)
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
    , .tap_data_mirror(tap_mirror_a)
`endif
  );

  fir_sample_buffer #(.DATA_BITS(16), .NUMBER_OF_TAPS(NB), .NUM_CHANNELS(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_channel(in_ch_b), .in_data(in_data_b),
    .tap_valid(tap_valid_b), .tap_ready(tap_ready_b), .tap_channel(tap_ch_b),
    .tap_index(tap_index_b), .tap_last(tap_last_b), .tap_data(tap_data_b)
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
    , .tap_data_mirror(tap_mirror_b)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: history per channel, index k = sample k steps older.
  int hist_a [CA][$];
  int hist_b [$];

  function automatic int exp_a(input int ch, input int k);
    return (k < hist_a[ch].size()) ? hist_a[ch][k] : 0;
  endfunction

  function automatic int exp_b(input int k);
    return (k < hist_b.size()) ? hist_b[k] : 0;
  endfunction

  // Offer one sample on A, then follow its whole tap sequence.
  // stall_pct: random tap_ready drop rate; hold_k: force a 3-cycle stall at
  // that index; abort_k: assert flush (with a competing in_valid) at that index.
  task automatic a_run(input int ch, input int d, input int stall_pct,
                       input int hold_k, input int abort_k);
    int k, cyc, stalls, held;
    bit done, rdy;
    @(negedge clk);
    check("a_in_ready_idle", in_ready_a, 1);
    in_valid_a = 1'b1;
    in_ch_a    = ch[0:0];
    in_data_a  = d[15:0];
    @(negedge clk);
    in_valid_a = 1'b0;
    hist_a[ch].push_front(d);
    if (hist_a[ch].size() > NA) void'(hist_a[ch].pop_back());
    k = 0; cyc = 0; stalls = 0; held = 0; done = 1'b0;
    while (!done && cyc < 500) begin
      if (k == abort_k) begin
        flush_a     = 1'b1;
        in_valid_a  = 1'b1;
        in_data_a   = 16'sd777;
        tap_ready_a = 1'b1;
        @(negedge clk);
        flush_a    = 1'b0;
        in_valid_a = 1'b0;
        for (int c = 0; c < CA; c++) hist_a[c].delete();
        check("a_flush_tap_valid", tap_valid_a, 0);
        check("a_flush_in_ready", in_ready_a, 1);
        check("a_flush_tap_last", tap_last_a, 0);
        check("a_flush_tap_data", tap_data_a, 0);
        return;
      end
      rdy = ($urandom_range(0, 99) >= stall_pct);
      if (k == hold_k && held < 3) begin
        rdy = 1'b0;
        held++;
      end
      tap_ready_a = rdy;
      check("a_tap_valid", tap_valid_a, 1);
      check("a_in_ready_busy", in_ready_a, 0);
      check("a_tap_index", tap_index_a, k);
      check("a_tap_channel", tap_ch_a, ch);
      check($sformatf("a_tap_data ch%0d k%0d", ch, k), tap_data_a, exp_a(ch, k));
      check("a_tap_last", tap_last_a, int'(k == KLA));
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
      check($sformatf("a_tap_mirror ch%0d k%0d", ch, k), tap_mirror_a, exp_a(ch, NA - 1 - k));
`endif
      cyc++;
      if (rdy) begin
        if (k == KLA) done = 1'b1;
        else k++;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    tap_ready_a = 1'b0;
    check("a_seq_done_in_time", int'(done), 1);
    check("a_seq_len", cyc, KLA + 1 + stalls);
    check("a_post_tap_valid", tap_valid_a, 0);
    check("a_post_in_ready", in_ready_a, 1);
  endtask

  task automatic b_run(input int d, input int stall_pct);
    int k, cyc, stalls;
    bit done, rdy;
    @(negedge clk);
    check("b_in_ready_idle", in_ready_b, 1);
    in_valid_b = 1'b1;
    in_data_b  = d[15:0];
    @(negedge clk);
    in_valid_b = 1'b0;
    hist_b.push_front(d);
    if (hist_b.size() > NB) void'(hist_b.pop_back());
    k = 0; cyc = 0; stalls = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      rdy = ($urandom_range(0, 99) >= stall_pct);
      tap_ready_b = rdy;
      check("b_tap_valid", tap_valid_b, 1);
      check("b_tap_index", tap_index_b, k);
      check($sformatf("b_tap_data k%0d", k), tap_data_b, exp_b(k));
      check("b_tap_last", tap_last_b, int'(k == KLB));
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
      check($sformatf("b_tap_mirror k%0d", k), tap_mirror_b, exp_b(NB - 1 - k));
`endif
      cyc++;
      if (rdy) begin
        if (k == KLB) done = 1'b1;
        else k++;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    tap_ready_b = 1'b0;
    check("b_seq_done_in_time", int'(done), 1);
    check("b_seq_len", cyc, KLB + 1 + stalls);
    check("b_post_in_ready", in_ready_b, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready_a", in_ready_a, 1);
    check("rst_tap_valid_a", tap_valid_a, 0);
    check("rst_tap_last_a", tap_last_a, 0);
    check("rst_tap_index_a", tap_index_a, 0);
    check("rst_tap_channel_a", tap_ch_a, 0);
    check("rst_tap_data_a", tap_data_a, 0);
    check("rst_in_ready_b", in_ready_b, 1);
    check("rst_tap_valid_b", tap_valid_b, 0);
`ifdef FIR_SAMPLE_BUFFER_SYMMETRIC_EN
    check("rst_tap_mirror_a", tap_mirror_a, 0);
`endif
    rst = 1'b0;

    // Single channel basics, then channel interleave.
    for (int i = 1; i <= 3; i++) a_run(0, i, 0, -1, -1);
    a_run(0, 100, 0, -1, -1);
    a_run(1, -5, 0, -1, -1);
    a_run(0, 101, 0, -1, -1);
    // Backpressure held at k=10.
    a_run(1, 4321, 0, 10, -1);
    // Flush at k=20 racing an in_valid; histories restart from zero.
    a_run(0, 55, 0, -1, 20);
    a_run(0, 9, 0, -1, -1);
    a_run(1, -9, 0, -1, -1);
    // Randomized traffic with random stalls.
    repeat (30) begin
      a_run(int'($urandom_range(0, CA - 1)), int'($urandom_range(0, 65535)) - 32768,
            25, -1, -1);
    end

    // Non-power-of-two (or fold-mode) depth: wrap head and tap addresses.
    for (int i = 1; i <= NB + 2; i++) b_run(i, (i > 3) ? 30 : 0);
    repeat (8) b_run(int'($urandom_range(0, 65535)) - 32768, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
